// File: rtl/axu_mem_pkg.sv
// Shared types and helpers for the SRAM target: access-size encodings, FSM states, lane masks.
// The ACCESS2 state exists only when AXU_MEM_MISALIGN_SPLIT_EN is defined.
package axu_mem_pkg;

  typedef enum logic [1:0] {
    AXU_ASIZE_BYTE = 2'd0,
    AXU_ASIZE_HALF = 2'd1,
    AXU_ASIZE_WORD = 2'd2,
    AXU_ASIZE_RSVD = 2'd3
  } axu_asize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
    ST_ACCESS2,
`endif
    ST_DONE
  } axu_state_e;

  // Lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [3:0] axu_byte_en(input logic [1:0] asize, input logic [1:0] off);
    logic [3:0] m;
    case (asize)
      AXU_ASIZE_BYTE: m = 4'b0001;
      AXU_ASIZE_HALF: m = 4'b0011;
      AXU_ASIZE_WORD: m = 4'b1111;
      default:        m = 4'b0000;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/axu_lane_align.sv
// Combinational lane steering: write data into byte lanes, read data right-aligned and
// zero-extended; with hi_i set it works on the upper word of a two-word (split) access.
module axu_lane_align
  import axu_mem_pkg::*;
(
  input  logic [1:0]  asize_i,
  input  logic [1:0]  off_i,
  input  logic        hi_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_prev_i,
  input  logic [31:0] rd_cur_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  size_m;
  logic [7:0]  be8;
  logic [63:0] w64;
  logic [63:0] r64;

  always_comb begin
    size_m  = axu_byte_en(asize_i, 2'b00);
    be8     = {4'b0000, size_m} << off_i;
    w64     = {32'b0, wdata_i} << {off_i, 3'b000};
    r64     = hi_i ? {rd_cur_i, rd_prev_i} : {32'b0, rd_cur_i};
    be_o    = hi_i ? be8[7:4] : be8[3:0];
    wlane_o = hi_i ? w64[63:32] : w64[31:0];
    rdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (size_m[k]) rdata_o[8*k +: 8] = r64[8*k + 8*int'(off_i) +: 8];
    end
  end

endmodule

// File: rtl/axu_mem_sram_target.sv
// Word-organised SRAM responder for the combined re/we memory port, with wait states and faults.
// Define AXU_MEM_MISALIGN_SPLIT_EN to split misaligned half/word accesses over two words.
//
// state    | meaning
// IDLE     | waiting for re|we; request captured here
// WAIT     | burning WAIT_CYCLES before the array access
// ACCESS   | array read/write of the addressed word
// ACCESS2  | second word of a split misaligned access (macro only)
// DONE     | ready (and fault if rejected) pulse
module axu_mem_sram_target
  import axu_mem_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic        we,
  input  logic [1:0]  asize,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        ready,
  output logic        fault
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
  localparam logic [7:0]  WAIT_LD = 8'(WAIT_CYCLES);

  axu_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    asize_q, asize_d;
  logic          we_q, we_d;
  logic          rej_q, rej_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_q, rd_d;
  logic [7:0]    cnt_q, cnt_d;
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
  logic          split_q, split_d;
  logic [31:0]   lo_q, lo_d;
`endif

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   req_off;
  logic          misalign;
  logic          hi;
  logic [AW-1:0] ridx;
  logic [31:0]   rd_prev;
  logic [3:0]    be;
  logic [31:0]   bemask, wlane, rdata;
  logic          mem_we;

  assign req_off  = addr - BASE;
  assign misalign = (asize == AXU_ASIZE_HALF && req_off[0]) ||
                    (asize == AXU_ASIZE_WORD && req_off[1:0] != 2'b00);

`ifdef AXU_MEM_MISALIGN_SPLIT_EN
  assign hi      = (state_q == ST_ACCESS2);
  assign rd_prev = lo_q;
`else
  assign hi      = 1'b0;
  assign rd_prev = '0;
`endif
  assign ridx = hi ? idx_q + AW'(1) : idx_q;

  axu_lane_align u_lane (
    .asize_i  (asize_q),
    .off_i    (off_q),
    .hi_i     (hi),
    .wdata_i  (wdata_q),
    .rd_prev_i(rd_prev),
    .rd_cur_i (mem_q[ridx]),
    .be_o     (be),
    .wlane_o  (wlane),
    .rdata_o  (rdata)
  );

  assign bemask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  // Drive follows the live re/we so the bus releases as soon as the initiator lets go.
  assign data   = (re && !we && state_q != ST_IDLE) ? rd_q : 'z;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    asize_d = asize_q;
    we_d    = we_q;
    rej_d   = rej_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
    split_d = split_q;
    lo_d    = lo_q;
`endif
    mem_we  = 1'b0;
    ready   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (re || we) begin
          idx_d   = req_off[AW+1:2];
          off_d   = req_off[1:0];
          asize_d = asize;
          we_d    = we;
          if (we) wdata_d = data;
          cnt_d   = WAIT_LD;
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
          split_d = misalign;
          rej_d   = (asize == AXU_ASIZE_RSVD) || (req_off >= SPAN) ||
                    (misalign && req_off[AW+1:2] == AW'(DEPTH - 1));
`else
          rej_d   = (asize == AXU_ASIZE_RSVD) || (req_off >= SPAN) || misalign;
`endif
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd1) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (rej_q) begin
          rd_d = '0;
        end else begin
          if (we_q) mem_we = 1'b1;
          else      rd_d   = rdata;
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
          lo_d = mem_q[idx_q];
          if (split_q) state_d = ST_ACCESS2;
`endif
        end
      end
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
      ST_ACCESS2: begin
        state_d = ST_DONE;
        if (we_q) mem_we = 1'b1;
        else      rd_d   = rdata;
      end
`endif
      ST_DONE: begin
        ready   = 1'b1;
        fault   = rej_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      asize_q <= '0;
      we_q    <= 1'b0;
      rej_q   <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      asize_q <= asize_d;
      we_q    <= we_d;
      rej_q   <= rej_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
      split_q <= split_d;
      lo_q    <= lo_d;
`endif
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ridx] <= (mem_q[ridx] & ~bemask) | (wlane & bemask);
  end

endmodule

// File: tb/tb_axu_mem_sram_target.sv
// Bench for axu_mem_sram_target: one instance with no wait states, one with three, checked
// against a byte-array memory model. Honours AXU_MEM_MISALIGN_SPLIT_EN when defined.
module tb_axu_mem_sram_target;

  localparam int          DEPTH = 32;
  localparam int          MEMB  = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        re_s    [2];
  logic        we_s    [2];
  logic [1:0]  asz_s   [2];
  logic [31:0] addr_s  [2];
  logic        drv_en  [2];
  logic [31:0] drv_val [2];
  wire  [31:0] data0, data1;
  wire         ready0, ready1, fault0, fault1;

  assign data0 = drv_en[0] ? drv_val[0] : 32'bz;
  assign data1 = drv_en[1] ? drv_val[1] : 32'bz;

  axu_mem_sram_target #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .re(re_s[0]), .we(we_s[0]), .asize(asz_s[0]),
    .addr(addr_s[0]), .data(data0), .ready(ready0), .fault(fault0));

  axu_mem_sram_target #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .re(re_s[1]), .we(we_s[1]), .asize(asz_s[1]),
    .addr(addr_s[1]), .data(data1), .ready(ready1), .fault(fault1));

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] mb [2][MEMB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (sz == 2'd3) return 1'b1;
    if (off >= 32'(MEMB)) return 1'b1;
    if ((off % (32'd1 << sz)) != 0) begin
`ifdef AXU_MEM_MISALIGN_SPLIT_EN
      return (off / 4 + 1 >= 32'(DEPTH));
`else
      return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic int m_latency(input int s, input logic [1:0] sz, input logic [31:0] a);
    int lat;
    lat = 2 + ((s == 1) ? 3 : 0);
    if (!m_fault(sz, a) && ((a - BASE) % (32'd1 << sz)) != 0) lat++;
    return lat;
  endfunction

  function automatic logic [31:0] m_read(input int s, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] v;
    int          off;
    v   = '0;
    off = int'(a - BASE);
    for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = mb[s][off + i];
    return v;
  endfunction

  task automatic m_write(input int s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int off;
    off = int'(a - BASE);
    for (int i = 0; i < (1 << sz); i++) mb[s][off + i] = wd[8*i +: 8];
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      re_s[i] = 1'b0; we_s[i] = 1'b0; asz_s[i] = 2'd0; addr_s[i] = '0;
      drv_en[i] = 1'b0; drv_val[i] = '0;
    end
  endtask

  // Starts and ends on a falling edge; holds re/we until ready unless drop_after > 0.
  task automatic txn(input int s, input logic is_wr, input logic also_re, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input int drop_after,
                     input string tag);
    logic        exp_f, got, rdy, flt;
    logic [31:0] exp_d, dbus;
    int          exp_lat, cyc;
    exp_f   = m_fault(sz, a);
    exp_lat = m_latency(s, sz, a);
    exp_d   = (exp_f || is_wr) ? 32'h0 : m_read(s, sz, a);
    re_s[s] = !is_wr || also_re; we_s[s] = is_wr; asz_s[s] = sz; addr_s[s] = a;
    drv_en[s] = is_wr; drv_val[s] = wd;
    cyc = 0; got = 1'b0; flt = 1'b0; dbus = '0;
    while (!got && cyc < 30) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rdy  = (s == 0) ? ready0 : ready1;
      flt  = (s == 0) ? fault0 : fault1;
      dbus = (s == 0) ? data0 : data1;
      if (rdy) got = 1'b1;
      if (cyc == drop_after) begin re_s[s] = 1'b0; we_s[s] = 1'b0; drv_en[s] = 1'b0; end
    end
    check({tag, " ready"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, " fault"}, 32'(flt), 32'(exp_f));
      if (!is_wr && drop_after == 0) check({tag, " rdata"}, dbus, exp_d);
      if (drop_after > 0) check({tag, " bus released"}, 32'((dbus === 32'bz) || (dbus === 32'h0)), 32'd1);
    end
    if (is_wr && !exp_f) m_write(s, sz, a, wd);
    re_s[s] = 1'b0; we_s[s] = 1'b0; drv_en[s] = 1'b0;
    @(negedge clk);
    rdy = (s == 0) ? ready0 : ready1;
    check({tag, " pulse end"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        wr;
    int          kind;

    rst_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    check("reset ready0", 32'(ready0), 32'd0);
    check("reset fault0", 32'(fault0), 32'd0);
    check("reset ready3", 32'(ready1), 32'd0);
    check("reset fault3", 32'(fault1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known contents everywhere (nonzero words).
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        txn(s, 1'b1, 1'b0, 2'd2, BASE + 32'(w * 4), $urandom | 32'h1, 0, "init");

    txn(0, 1'b1, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 0, "t1 wr");
    txn(0, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 0, "t1 rd");
    txn(0, 1'b1, 1'b0, 2'd0, 32'h13, 32'h0000005A, 0, "t2 wrb");
    txn(0, 1'b0, 1'b0, 2'd1, 32'h12, 32'h0, 0, "t2 rdh");
    txn(0, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 0, "t2 rdw");

    txn(1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 0, "t3 rd");
    txn(1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1, "t3 drop");

    txn(0, 1'b0, 1'b0, 2'd2, 32'(MEMB), 32'h0, 0, "t4 range");
    txn(0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 0, "t4 rsvd");
    txn(0, 1'b1, 1'b0, 2'd2, 32'h0, 32'hCAFEF00D, 0, "t4 wr");
    txn(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 0, "t4 rd");

    txn(0, 1'b1, 1'b0, 2'd2, 32'h2, 32'h11223344, 0, "t5 wr");
    txn(0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 0, "t5 rd0");
    txn(0, 1'b0, 1'b0, 2'd2, 32'h4, 32'h0, 0, "t5 rd4");

    // Reset during WAIT of a write: nothing committed.
    re_s[1] = 1'b0; we_s[1] = 1'b1; asz_s[1] = 2'd2; addr_s[1] = 32'h20;
    drv_en[1] = 1'b1; drv_val[1] = ~m_read(1, 2'd2, 32'h20);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("t6 ready", 32'(ready1), 32'd0);
    check("t6 fault", 32'(fault1), 32'd0);
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1, 1'b0, 1'b0, 2'd2, 32'h20, 32'h0, 0, "t6 rd");

    // Reset during the ready/fault pulse clears them at once.
    re_s[0] = 1'b1; asz_s[0] = 2'd2; addr_s[0] = 32'(MEMB);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("t6b ready", 32'(ready0), 32'd1);
    check("t6b fault", 32'(fault0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6b ready rst", 32'(ready0), 32'd0);
    check("t6b fault rst", 32'(fault0), 32'd0);
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      for (int t = 0; t < 60; t++) begin
        kind = int'($urandom_range(0, 9));
        if (kind < 7)      a = 32'($urandom_range(0, MEMB - 1));
        else if (kind < 9) a = 32'(MEMB) + 32'($urandom_range(0, 15));
        else               a = 32'hFFFF_FFFC;
        a  = a + BASE;
        sz = 2'($urandom_range(0, 3));
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        txn(s, wr, 1'($urandom_range(0, 1)), sz, a, wd, 0, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
